useq_ctrl: RTL and testbench
============================

# useq_ctrl

Parametrised microprogram sequencer for the microcoded CPU datapath. Each cycle it latches the control-store word addressed by CAR into CBR and computes the next CAR. Sequencing modes: increment, opcode dispatch, fetch return, unconditional jump, conditional branch on datapath flags, micro-subroutine call/return through a hardware stack, and a true halt. It sits between the control-store ROM (asynchronous read of CAR) and the datapath, which decodes the CBR micro-operation fields.

## Interface
- AW, 8: control-store address width (CAR width).
- CW_W, 32: control word width (CBR/ROM width); must satisfy CW_W ≥ AW+24.
- OP_W, 8: IR width.
- NFLAG, 4: number of condition flags (1..8).
- DISP_SHIFT, 4: dispatch address = (IR << DISP_SHIFT) mod 2^AW.
- FETCH_ADDR, 0: fetch routine entry; also the reset value of CAR.
- RESET_CW, 32'h0000_0010: reset value of CBR.
- STACK_DEPTH, 4: return-stack entries (≥1).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- IR  in  OP_W  current instruction opcode.
- ROM  in  CW_W  control word at address CAR.
- flags  in  NFLAG  datapath condition flags (flags[0] = zero flag).
- stall  in  1  hold sequencer (wait for memory/multicycle ALU).
- CAR  out  AW  control address register.
- CBR  out  CW_W  control buffer register (current micro-instruction).
- halted  out  1  sequencer halted.
- stk_err  out  1  sticky stack overflow/underflow.
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy.

## Operation
- Control word fields (of ROM): next address NA = [CW_W-1 -: AW]; SEQ = [22:20]; condition select CSEL = [14:12]; condition invert CINV = [15]. CSEL/CINV are meaningful only when SEQ = BRANCH; elsewhere they are micro-operation bits and are ignored.
- Condition C = (CSEL < NFLAG ? flags[CSEL] : 0) XOR CINV.
- Next CAR by SEQ:
  - 000 INC: CAR+1, wraps mod 2^AW.
  - 001 DISPATCH: (IR << DISP_SHIFT) mod 2^AW.
  - 010 FETCH: FETCH_ADDR.
  - 011 JUMP: NA.
  - 100 HALT: CAR unchanged; halted set.
  - 101 BRANCH: C ? NA : CAR+1.
  - 110 CALL: push CAR+1, CAR = NA. If sp = STACK_DEPTH: push dropped, stk_err set, jump still taken.
  - 111 RETURN: pop into CAR. If sp = 0: CAR = FETCH_ADDR, stk_err set.
- Stack is LIFO; sp increments on successful push, decrements on successful pop; no other ops touch it.
- Priority per edge: RST > halted > stall > sequencing.
- halted: CAR, CBR, sp, stack hold; only RST clears it. stall ignored while halted.
- stall high (not halted): CAR, CBR, sp, stack, stk_err hold; ROM ignored.
- stk_err sticky until RST.
- Reset: CAR = FETCH_ADDR, CBR = RESET_CW, halted = 0, stk_err = 0, sp = 0; stack contents don't-care.

## Timing
- Single-cycle sequencer: on an active edge CBR <= ROM and CAR <= next address decoded from that same ROM word (the word at the old CAR). New CAR visible after the edge; ROM settles combinationally before the next edge.
- CBR therefore holds the micro-instruction fetched from the previous CAR; the datapath executes CBR during the cycle after the edge.
- halted asserts after the edge that latches a HALT word; CBR then shows that HALT word.
- RST asserted mid-call/mid-stall takes effect on that edge; stall/halt have no effect that cycle.
- Dispatch uses IR sampled at the edge; IR must be stable in the cycle the DISPATCH word is presented.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset/INC: assert RST one edge → CAR=00, CBR=32'h0000_0010, sp=0; then ROM words with SEQ=000 for 3 edges → CAR 01, 02, 03; at CAR=FF, INC → CAR=00.
- Dispatch: IR=8'h03, ROM SEQ=001 → CAR=30; IR=8'h1F → CAR=F0 (truncation); ROM SEQ=010 → CAR=00.
- Branch: flags=4'b0001, ROM SEQ=101, CSEL=0, CINV=0, NA=F2 at CAR=05 → CAR=F2; same with CINV=1 → CAR=06; CSEL=5 (≥NFLAG), CINV=0 → CAR=06.
- Call/return nesting: at CAR=10 CALL NA=80, at 80 CALL NA=90, at 90 RETURN → 81, at 81 RETURN → 11; sp sequence 1,2,1,0; stk_err=0. Five nested CALLs with STACK_DEPTH=4 → fifth jumps, sp stays 4, stk_err=1; RETURN at sp=0 → CAR=00, stk_err=1.
- Stall: stall=1 for 3 edges while ROM changes → CAR, CBR, sp unchanged; release → normal sequencing resumes from held CAR.
- Halt: ROM SEQ=100 at CAR=50 → halted=1, CAR=50 held for 10 edges regardless of ROM/stall/IR; RST → CAR=00, halted=0.

Source files
------------

// File: rtl/useq_ctrl.sv
// useq_ctrl: microprogram sequencer.
// Each active edge latches the control word at CAR into CBR and loads CAR with
// the next address decoded from that same word (INC, DISPATCH, FETCH, JUMP,
// HALT, BRANCH, CALL, RETURN). CALL/RETURN use a small hardware return stack.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   IR              opcode, used by DISPATCH
//   ROM             control word addressed by CAR (asynchronous ROM read)
//   flags           datapath condition flags, flags[0] = zero flag
//   stall           hold every piece of state for this edge
//   CAR, CBR        control address / control buffer registers
//   halted          set by a HALT word, cleared only by RST
//   stk_err         sticky stack overflow/underflow
//   sp              return-stack occupancy
module useq_ctrl #(
    parameter int                AW          = 8,
    parameter int                CW_W        = 32,
    parameter int                OP_W        = 8,
    parameter int                NFLAG       = 4,
    parameter int                DISP_SHIFT  = 4,
    parameter logic [AW-1:0]     FETCH_ADDR  = '0,
    parameter logic [CW_W-1:0]   RESET_CW    = 32'h0000_0010,
    parameter int                STACK_DEPTH = 4,
    parameter int                SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [OP_W-1:0]   IR,
    input  logic [CW_W-1:0]   ROM,
    input  logic [NFLAG-1:0]  flags,
    input  logic              stall,
    output logic [AW-1:0]     CAR,
    output logic [CW_W-1:0]   CBR,
    output logic              halted,
    output logic              stk_err,
    output logic [SP_W-1:0]   sp
);

    localparam logic [2:0] SEQ_INC    = 3'b000;
    localparam logic [2:0] SEQ_DISP   = 3'b001;
    localparam logic [2:0] SEQ_FETCH  = 3'b010;
    localparam logic [2:0] SEQ_JUMP   = 3'b011;
    localparam logic [2:0] SEQ_HALT   = 3'b100;
    localparam logic [2:0] SEQ_BRANCH = 3'b101;
    localparam logic [2:0] SEQ_CALL   = 3'b110;
    localparam logic [2:0] SEQ_RET    = 3'b111;

    logic [AW-1:0]   car_q, car_d;
    logic [CW_W-1:0] cbr_q;
    logic            halted_q, halted_d;
    logic            err_q;
    logic [SP_W-1:0] sp_q;
    logic [AW-1:0]   stack_q [STACK_DEPTH];

    logic [2:0]      seq;
    logic [2:0]      csel;
    logic            cinv;
    logic [AW-1:0]   na;
    logic [AW-1:0]   car_inc;
    logic [AW-1:0]   disp_addr;
    logic [OP_W+AW-1:0] disp_wide;
    logic [AW-1:0]   stk_top;
    logic            cond;
    logic            push, pop, err_set;
    logic            adv;

    assign seq     = ROM[22:20];
    assign csel    = ROM[14:12];
    assign cinv    = ROM[15];
    assign na      = ROM[CW_W-1 -: AW];
    assign car_inc = car_q + 1'b1;

    // Widen before shifting so the result is exactly (IR << DISP_SHIFT) mod 2^AW
    // for any shift amount.
    assign disp_wide = {{AW{1'b0}}, IR} << DISP_SHIFT;
    assign disp_addr = disp_wide[AW-1:0];

    // Only halted and stall block sequencing; RST is handled ahead of both.
    assign adv = !halted_q && !stall;

    // Out-of-range CSEL reads as a false flag before inversion.
    always_comb begin
        cond = 1'b0;
        for (int i = 0; i < NFLAG; i++)
            if (csel == 3'(i)) cond = flags[i];
        cond = cond ^ cinv;
    end

    always_comb begin
        stk_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp_q == SP_W'(i + 1)) stk_top = stack_q[i];
    end

    always_comb begin
        car_d    = car_inc;
        halted_d = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        err_set  = 1'b0;
        case (seq)
            SEQ_INC:    car_d = car_inc;
            SEQ_DISP:   car_d = disp_addr;
            SEQ_FETCH:  car_d = FETCH_ADDR;
            SEQ_JUMP:   car_d = na;
            SEQ_HALT: begin
                car_d    = car_q;
                halted_d = 1'b1;
            end
            SEQ_BRANCH: car_d = cond ? na : car_inc;
            SEQ_CALL: begin
                // A full stack drops the return address but the jump is still taken.
                car_d = na;
                if (sp_q == SP_W'(STACK_DEPTH)) err_set = 1'b1;
                else                            push    = 1'b1;
            end
            SEQ_RET: begin
                if (sp_q == '0) begin
                    car_d   = FETCH_ADDR;
                    err_set = 1'b1;
                end else begin
                    car_d = stk_top;
                    pop   = 1'b1;
                end
            end
            default: car_d = car_inc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            car_q    <= FETCH_ADDR;
            cbr_q    <= RESET_CW;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            sp_q     <= '0;
        end else if (adv) begin
            car_q    <= car_d;
            cbr_q    <= ROM;
            halted_q <= halted_d;
            if (err_set) err_q <= 1'b1;
            if (push)    sp_q  <= sp_q + 1'b1;
            else if (pop) sp_q <= sp_q - 1'b1;
        end
    end

    // Stack contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (!RST && adv && push) begin
            for (int i = 0; i < STACK_DEPTH; i++)
                if (sp_q == SP_W'(i)) stack_q[i] <= car_inc;
        end
    end

    assign CAR     = car_q;
    assign CBR     = cbr_q;
    assign halted  = halted_q;
    assign stk_err = err_q;
    assign sp      = sp_q;

endmodule

// File: tb/tb_useq_ctrl.sv
module tb_useq_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  IR = '0;
    logic [31:0] ROM;
    logic [3:0]  flags = '0;
    logic        stall = 1'b0;
    logic [7:0]  CAR;
    logic [31:0] CBR;
    logic        halted;
    logic        stk_err;
    logic [2:0]  sp;

    // ROM source: either a directly driven word or a random control store
    // read asynchronously at the DUT's CAR.
    logic [31:0] rom_drv = '0;
    logic        use_mem = 1'b0;
    logic [31:0] mem [256];
    assign ROM = use_mem ? mem[CAR] : rom_drv;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_car;
    logic [31:0] m_cbr;
    bit          m_halt;
    bit          m_err;
    int          m_stk[$];

    useq_ctrl dut (
        .CLK(CLK), .RST(RST), .IR(IR), .ROM(ROM), .flags(flags), .stall(stall),
        .CAR(CAR), .CBR(CBR), .halted(halted), .stk_err(stk_err), .sp(sp)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input int seq, input int na, input int csel = 0,
                                        input int cinv = 0);
        logic [31:0] w;
        w = '0;
        w[31:24] = 8'(na);
        w[22:20] = 3'(seq);
        w[15]    = 1'(cinv);
        w[14:12] = 3'(csel);
        return w;
    endfunction

    // One clock edge: advance the model from the inputs in force, then compare
    // every output shortly after the edge.
    task automatic step(input string tag);
        logic [31:0] w;
        int seq, na, csel, c;
        w = use_mem ? mem[m_car] : rom_drv;
        @(posedge CLK);
        if (RST) begin
            m_car = 0; m_cbr = 32'h10; m_halt = 0; m_err = 0; m_stk.delete();
        end else if (!m_halt && !stall) begin
            seq  = int'(w[22:20]);
            na   = int'(w[31:24]);
            csel = int'(w[14:12]);
            m_cbr = w;
            case (seq)
                0: m_car = (m_car + 1) % 256;
                1: m_car = (int'(IR) * (1 << 4)) % 256;
                2: m_car = 0;
                3: m_car = na;
                4: m_halt = 1;
                5: begin
                    c = (csel < 4) ? int'(flags[csel]) : 0;
                    c = c ^ int'(w[15]);
                    m_car = c ? na : (m_car + 1) % 256;
                end
                6: begin
                    if (m_stk.size() == 4) m_err = 1;
                    else m_stk.push_back((m_car + 1) % 256);
                    m_car = na;
                end
                default: begin
                    if (m_stk.size() == 0) begin m_err = 1; m_car = 0; end
                    else m_car = m_stk.pop_back();
                end
            endcase
        end
        #1;
        chk({tag, ".CAR"}, CAR, 64'(m_car));
        chk({tag, ".CBR"}, CBR, 64'(m_cbr));
        chk({tag, ".halted"}, halted, 64'(m_halt));
        chk({tag, ".stk_err"}, stk_err, 64'(m_err));
        chk({tag, ".sp"}, sp, 64'(m_stk.size()));
    endtask

    task automatic do_reset();
        RST = 1'b1; step("rst"); RST = 1'b0;
    endtask

    task automatic go(input int addr);
        rom_drv = mkw(3, addr); step("jmp");
    endtask

    task automatic run(input logic [31:0] w, input string tag);
        rom_drv = w; step(tag);
    endtask

    initial begin
        m_car = 0; m_cbr = '0; m_halt = 0; m_err = 0;
        foreach (mem[i]) mem[i] = '0;

        // Reset and increment, including wrap at FF
        do_reset();
        chk("rst.CAR0", CAR, 64'h0);
        chk("rst.CBR", CBR, 64'h10);
        repeat (3) run(mkw(0, 8'hAA), "inc");
        chk("inc.CAR3", CAR, 64'h3);
        go(8'hFF);
        run(mkw(0, 0), "inc_wrap");
        chk("inc.wrap", CAR, 64'h0);

        // Dispatch with truncation, then fetch
        IR = 8'h03; run(mkw(1, 0), "disp");
        chk("disp.30", CAR, 64'h30);
        IR = 8'h1F; run(mkw(1, 0), "disp_tr");
        chk("disp.F0", CAR, 64'hF0);
        run(mkw(2, 8'h77), "fetch");

        // Conditional branch: taken, inverted, out-of-range select
        flags = 4'b0001;
        go(8'h05); run(mkw(5, 8'hF2, 0, 0), "br_t");
        chk("br.taken", CAR, 64'hF2);
        go(8'h05); run(mkw(5, 8'hF2, 0, 1), "br_inv");
        chk("br.inv", CAR, 64'h06);
        go(8'h05); run(mkw(5, 8'hF2, 5, 0), "br_oor");
        chk("br.oor", CAR, 64'h06);

        // Nested call/return
        go(8'h10);
        run(mkw(6, 8'h80), "call1");
        run(mkw(6, 8'h90), "call2");
        run(mkw(7, 0), "ret1");
        chk("ret.81", CAR, 64'h81);
        run(mkw(7, 0), "ret2");
        chk("ret.11", CAR, 64'h11);

        // Overflow on fifth call, underflow after reset
        for (int i = 0; i < 5; i++) run(mkw(6, 8'h20 + i), "ovf");
        chk("ovf.sp", sp, 64'h4);
        chk("ovf.err", stk_err, 64'h1);
        do_reset();
        go(8'h33);
        run(mkw(7, 0), "unf");
        chk("unf.CAR", CAR, 64'h0);
        chk("unf.err", stk_err, 64'h1);

        // Stall holds everything while ROM changes
        do_reset();
        go(8'h40);
        run(mkw(6, 8'h60), "pre_stall");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) run($urandom, "stall");
        stall = 1'b0;
        run(mkw(0, 0), "post_stall");
        chk("stall.resume", CAR, 64'h61);

        // Halt ignores ROM, stall and IR until reset
        go(8'h50);
        run(mkw(4, 8'h12), "halt");
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom); IR = 8'($urandom); flags = 4'($urandom);
            run($urandom, "halted");
        end
        chk("halt.CAR", CAR, 64'h50);
        stall = 1'b0;
        do_reset();
        chk("halt.clr", halted, 64'h0);

        // Randomized runs from a random control store; halts made rarer
        use_mem = 1'b1;
        for (int seg = 0; seg < 30; seg++) begin
            foreach (mem[i]) begin
                mem[i] = $urandom;
                if (mem[i][22:20] == 3'd4 && $urandom_range(7) != 0) mem[i][22:20] = 3'd0;
            end
            do_reset();
            for (int n = 0; n < 60; n++) begin
                stall = ($urandom_range(4) == 0);
                IR    = 8'($urandom);
                flags = 4'($urandom);
                RST   = ($urandom_range(80) == 0);
                step("rand");
            end
            RST = 1'b0; stall = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
